// File: rtl/qonv_pkg.sv
// Shared types and constants for the quantised-convolution datapath.
package qonv_pkg;

  localparam int ACT_BITS        = 8;
  localparam int ACC_SHIFT_WIDTH = 20;

  localparam int ACT_MAX = (2 ** (ACT_BITS - 1)) - 1;
  localparam int ACT_MIN = -(2 ** (ACT_BITS - 1));

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturator from IN_WIDTH down to OUT_BITS.
// Optional macro REQUANT_RELU_EN: negative results are forced to zero (not counted as clamps).
module sat_clamp
  import qonv_pkg::*;
#(
  parameter int IN_WIDTH = ACC_SHIFT_WIDTH,
  parameter int OUT_BITS = ACT_BITS
) (
  input  logic signed [IN_WIDTH-1:0] data_i,
  output logic        [OUT_BITS-1:0] data_o,
  output logic                       clamped_o
);

  localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
  // Bitwise inverse of the positive limit is exactly -2^(OUT_BITS-1).
  localparam logic signed [IN_WIDTH-1:0] LO = ~HI;

  always_comb begin
    data_o    = data_i[OUT_BITS-1:0];
    clamped_o = 1'b0;
    if (data_i > HI) begin
      data_o    = HI[OUT_BITS-1:0];
      clamped_o = 1'b1;
    end else if (data_i < LO) begin
`ifdef REQUANT_RELU_EN
      data_o    = '0;
`else
      data_o    = LO[OUT_BITS-1:0];
      clamped_o = 1'b1;
`endif
    end
`ifdef REQUANT_RELU_EN
    else if (data_i[IN_WIDTH-1]) begin
      data_o = '0;
    end
`endif
  end

endmodule

// File: rtl/requant_packer.sv
// Saturates shifter output to activations and packs LANES of them per output word.
// Optional macro REQUANT_RELU_EN selects ReLU clamping inside sat_clamp.
module requant_packer
  import qonv_pkg::*;
#(
  parameter int IN_WIDTH = ACC_SHIFT_WIDTH,
  parameter int OUT_BITS = ACT_BITS,
  parameter int LANES    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [LANES*OUT_BITS-1:0]    out_data,
  output logic [LANES-1:0]             out_keep,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  sat_count
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = LANES * OUT_BITS;

  pack_state_t      state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [WW-1:0]    pack_q, pack_d, odata_q, odata_d;
  logic [LANES-1:0] pkeep_q, pkeep_d, okeep_q, okeep_d;
  logic             plast_q, plast_d, olast_q, olast_d, ovalid_q, ovalid_d;
  logic [15:0]      sat_q, sat_d;

  logic [OUT_BITS-1:0] act;
  logic                clamped;
  logic                accept, out_free, complete;
  logic [WW-1:0]       word;
  logic [LANES-1:0]    keep;

  sat_clamp #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_BITS (OUT_BITS)
  ) u_clamp (
    .data_i    (in_data),
    .data_o    (act),
    .clamped_o (clamped)
  );

  assign in_ready  = (state_q == FILL);
  assign out_data  = odata_q;
  assign out_keep  = okeep_q;
  assign out_last  = olast_q;
  assign out_valid = ovalid_q;
  assign sat_count = sat_q;

  always_comb begin
    accept   = in_valid && (state_q == FILL);
    out_free = !ovalid_q || out_ready;
    word     = pack_q;
    word[int'(lane_q)*OUT_BITS +: OUT_BITS] = act;
    keep     = pkeep_q;
    keep[lane_q] = 1'b1;
    complete = (lane_q == LW'(LANES - 1)) || in_last;

    state_d  = state_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    pkeep_d  = pkeep_q;
    plast_d  = plast_q;
    odata_d  = odata_q;
    okeep_d  = okeep_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;
    sat_d    = sat_q;

    if (ovalid_q && out_ready) ovalid_d = 1'b0;

    // HOLD and accept are exclusive, so at most one of these loads the output register.
    if (state_q == HOLD && out_free) begin
      odata_d  = pack_q;
      okeep_d  = pkeep_q;
      olast_d  = plast_q;
      ovalid_d = 1'b1;
      pack_d   = '0;
      pkeep_d  = '0;
      plast_d  = 1'b0;
      state_d  = FILL;
    end

    if (accept) begin
      if (clamped && sat_q != '1) sat_d = sat_q + 16'd1;
      if (!complete) begin
        pack_d  = word;
        pkeep_d = keep;
        lane_d  = lane_q + LW'(1);
      end else begin
        lane_d = '0;
        if (out_free) begin
          odata_d  = word;
          okeep_d  = keep;
          olast_d  = in_last;
          ovalid_d = 1'b1;
          pack_d   = '0;
          pkeep_d  = '0;
        end else begin
          pack_d  = word;
          pkeep_d = keep;
          plast_d = in_last;
          state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      lane_q   <= '0;
      pack_q   <= '0;
      pkeep_q  <= '0;
      plast_q  <= 1'b0;
      odata_q  <= '0;
      okeep_q  <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
      sat_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      pkeep_q  <= pkeep_d;
      plast_q  <= plast_d;
      odata_q  <= odata_d;
      okeep_q  <= okeep_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_requant_packer.sv
// Scoreboard bench for requant_packer: expected words queued on accept, compared on output handshake.
module tb_requant_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last, out_valid, out_ready;
  logic [15:0] sat_count;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t exp_q[$];

  int n_vec  = 0;
  int n_err  = 0;
  int stalls = 0;
  bit rnd_on = 1'b0;

  // Independent reference model state
  logic [31:0] m_word;
  logic [3:0]  m_keep;
  int          m_lane;
  int          m_sat;

  requant_packer #(
    .IN_WIDTH (20),
    .OUT_BITS (8),
    .LANES    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mclamp(input int v);
`ifdef REQUANT_RELU_EN
    if (v > 127) return 127;
    if (v < 0) return 0;
    return v;
`else
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`endif
  endfunction

  function automatic bit mcounts(input int v);
`ifdef REQUANT_RELU_EN
    return v > 127;
`else
    return (v > 127) || (v < -128);
`endif
  endfunction

  task automatic model_reset();
    m_word = '0;
    m_keep = '0;
    m_lane = 0;
    m_sat  = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int v, input bit last);
    int    c;
    word_t w;
    c = mclamp(v);
    m_word[8*m_lane +: 8] = c[7:0];
    m_keep[m_lane] = 1'b1;
    if (mcounts(v) && m_sat < 65535) m_sat++;
    m_lane++;
    if (m_lane == 4 || last) begin
      w.data = m_word;
      w.keep = m_keep;
      w.last = last;
      exp_q.push_back(w);
      m_word = '0;
      m_keep = '0;
      m_lane = 0;
    end
  endtask

  // Called just after a posedge; returns just after the posedge on which the sample was taken.
  task automatic send(input int v, input bit last);
    int  cyc;
    bit  ok;
    logic [31:0] vv;
    vv       = v;
    in_valid = 1'b1;
    in_data  = vv[19:0];
    in_last  = last;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        stalls++;
        cyc++;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    else model_accept(v, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_data  = 20'h80000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_out_keep"},  64'(out_keep),  64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_sat_count"}, 64'(sat_count), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_word", 64'(out_data), 64'hDEAD);
      else begin
        word_t e;
        e = exp_q.pop_front();
        chk("word_data", 64'(out_data), 64'(e.data));
        chk("word_keep", 64'(out_keep), 64'(e.keep));
        chk("word_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("por");
    @(posedge clk);
    #1;

    // Simple packing and one-cycle latency
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    @(negedge clk);
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_data",  64'(out_data),  64'h04030201);
    idle(1);
    drain("drain_basic");

    // Saturation
    send(300, 0); send(-300, 0); send(127, 0); send(-128, 0);
    idle(2);
    chk("sat_count_a", 64'(sat_count), 64'(m_sat));
    send(128, 0); send(-129, 0); send(126, 0); send(-127, 0);
    idle(2);
    chk("sat_count_b", 64'(sat_count), 64'(m_sat));

    // Idle in_last/in_data junk must be ignored; partial flush via last
    idle(3);
    chk("idle_sat", 64'(sat_count), 64'(m_sat));
    send(5, 0); send(6, 1);
    send(7, 0); send(8, 0); send(9, 0); send(10, 0);
    // last on the fourth lane: a single full word, no empty follower
    send(11, 0); send(12, 0); send(13, 0); send(14, 1);
    idle(3);
    drain("drain_last");

    // Throughput: back-to-back samples with no bubbles
    stalls = 0;
    for (int i = 0; i < 16; i++) send(i * 37 - 250, 0);
    chk("no_bubbles", 64'(stalls), 64'd0);
    idle(2);
    drain("drain_stream");

    // Backpressure: first word held in output, second in pack register
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(20 + i, 0);
    @(negedge clk);
    chk("hold_in_ready", 64'(in_ready),  64'd0);
    chk("hold_valid",    64'(out_valid), 64'd1);
    held = out_data;
    idle(4);
    @(negedge clk);
    chk("hold_stable",   64'(out_data),  64'(held));
    chk("hold_ready2",   64'(in_ready),  64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 8; i < 12; i++) send(20 + i, 0);
    idle(2);
    drain("drain_backpressure");

    // Random values with random backpressure and random last
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++)
      send(int'($urandom_range(0, 1200)) - 600, ($urandom_range(0, 4) == 0));
    rnd_on = 1'b0;
    #2;
    out_ready = 1'b1;
    idle(2);
    drain("drain_random");
    chk("sat_count_rand", 64'(sat_count), 64'(m_sat));

    // Reset mid-word
    send(300, 0); send(2, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    send(-5, 0); send(66, 0); send(77, 0); send(88, 0);
    idle(2);
    drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
